au_sum_zero_det_seq: RTL and testbench
======================================

AU_SUM_ZERO_DET_SEQ -- requirements
Module: AU_sum_zero_det_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length of each operand slice (>= 1).
REQ-002 SHALL have parameter NWORDS, default 4, number of slices per operand (>= 2); total operand length is WIDTH*NWORDS.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, operation request; sampled only in IDLE.
REQ-006 SHALL have port ci, input, 1, carry-in of the full-length addition; sampled with start.
REQ-007 SHALL have port in_valid, input, 1, slice pair present on a/b.
REQ-008 SHALL have port in_ready, output, 1, block accepts a slice pair this cycle.
REQ-009 SHALL have port a, input, WIDTH, operand slice, least-significant slice first.
REQ-010 SHALL have port b, input, WIDTH, operand slice, least-significant slice first.
REQ-011 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-012 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-013 SHALL have port z, output, 1, all-zeros flag of (A + B + ci) mod 2^(WIDTH*NWORDS).

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1, latch ci into the carry register, clear the word counter, set the zero accumulator to 1, and go to RUN.
REQ-016 SHALL drive in_ready=1 only in RUN; transfer occurs when in_valid=1 and in_ready=1.
REQ-017 SHALL, per transfer, compute s = a + b + carry (WIDTH+1 bits), store bit WIDTH as the next carry, AND (s[WIDTH-1:0]==0) into the zero accumulator, and increment the word counter.
REQ-018 SHALL hold all state in RUN on cycles without a transfer (in_valid gaps allowed, unbounded).
REQ-019 SHALL, on the transfer with counter = NWORDS-1, go to DONE on the next cycle.
REQ-020 SHALL, in DONE, assert done=1 for exactly one cycle, load z with the final accumulator value, and return to IDLE.
REQ-021 SHALL discard the carry-out of the most-significant slice.
REQ-022 SHALL hold z stable from its DONE update until the next DONE update or reset.
REQ-023 SHALL ignore start while in RUN or DONE.
REQ-024 SHALL ignore in_valid in IDLE and DONE; no slice is consumed.
REQ-025 SHALL make done depend only on registered state; in_ready and busy are decoded from state only.
REQ-026 SHALL size the word counter as clog2(NWORDS) bits minimum; no wrap occurs inside one operation.
REQ-027 SHALL produce done exactly 1 cycle after the last transfer (latency NWORDS transfer cycles + 1 minimum from first transfer).

Reset
REQ-028 SHALL, when rst=1 on a clock edge, enter IDLE and set busy=0, done=0, in_ready=0, z=0, carry=0, counter=0, accumulator=1.
REQ-029 SHALL give rst priority over start, in_valid and any state transition, including mid-operation; the aborted operation produces no done.
REQ-030 SHALL accept a new start on the first cycle after rst deasserts.

Verification (WIDTH=8, NWORDS=4, slices listed LSW first)
REQ-031 SHALL check a=FF,FF,FF,FF, b=00,00,00,00, ci=1 -> done pulse, z=1.
REQ-032 SHALL check a=01,00,00,00, b=FF,FF,FF,FF, ci=0 (carry-out discarded) -> z=1; then a=FF,FF,FF,FF, b=00,00,00,00, ci=0 -> z=0.
REQ-033 SHALL check the same operands as REQ-031 with in_valid low 3 cycles between each slice -> same z=1, done 1 cycle after 4th transfer, in_ready high throughout RUN.
REQ-034 SHALL check rst asserted after 2 transfers -> next cycle IDLE, busy=0, z=0, no done; subsequent REQ-031 operation gives z=1.
REQ-035 SHALL check start pulsed during RUN and in_valid=1 during IDLE -> no effect on count, result or state.
REQ-036 SHALL compare z against a WIDTH*NWORDS-bit behavioural sum-zero model for >= 10000 random operands with random in_valid gaps.

Source files
------------

// File: rtl/au_sum_zero_det_seq.sv
//==============================================================================
// Module      : au_sum_zero_det_seq
// Description : Detects whether (A + B + ci) mod 2^(WIDTH*NWORDS) is all zeros,
//               with the operands streamed in as WIDTH-bit slices, LSW first.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module au_sum_zero_det_seq #(
   parameter int WIDTH  = 8,
   parameter int NWORDS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ci,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             z
);

   localparam int               CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               carry_q, carry_d;
   logic               acc_q,   acc_d;
   logic               z_q,     z_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   logic [WIDTH:0]     slice_sum;
   logic               slice_zero;
   logic               xfer;

   assign slice_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
   assign slice_zero = (slice_sum[WIDTH-1:0] == '0);
   assign xfer       = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         carry_q <= 1'b0;
         acc_q   <= 1'b1;
         z_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               carry_d = ci;
               cnt_d   = '0;
               acc_d   = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (xfer) begin
               carry_d = slice_sum[WIDTH];
               acc_d   = acc_q & slice_zero;
               cnt_d   = cnt_q + CNT_W'(1);
               // z is captured as DONE is entered so it is already valid while done is high;
               // the final slice's carry-out is simply never used.
               if (cnt_q == LAST_CNT) begin
                  z_d     = acc_q & slice_zero;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready = (state_q == S_RUN);
   assign busy     = (state_q == S_RUN) || (state_q == S_DONE);
   assign done     = (state_q == S_DONE);
   assign z        = z_q;

endmodule

`default_nettype wire

// File: tb/tb_au_sum_zero_det_seq.sv
//==============================================================================
// Module      : tb_au_sum_zero_det_seq
// Description : Scoreboard bench for au_sum_zero_det_seq (WIDTH=8, NWORDS=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_au_sum_zero_det_seq;

   localparam int WIDTH  = 8;
   localparam int NWORDS = 4;
   localparam int TW     = WIDTH * NWORDS;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             ci = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy;
   logic             done;
   logic             z;

   int n_vec = 0;
   int n_err = 0;
   bit exp_q[$];

   au_sum_zero_det_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ci       (ci),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .z        (z)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every done pulse must match the oldest outstanding expected result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) check_val("spurious_done", 1, 0);
         else                   check_val("z", z, exp_q.pop_front());
      end
   end

   task automatic do_op(input logic [TW-1:0] av, input logic [TW-1:0] bv, input logic cin,
                        input int gap, input bit rnd_gap, input bit poke);
      logic [TW:0] s;
      int          g;
      s = {1'b0, av} + {1'b0, bv} + {{TW{1'b0}}, cin};
      exp_q.push_back(s[TW-1:0] == '0);
      start = 1'b1;
      ci    = cin;
      @(posedge clk); #1;
      start = 1'b0;
      ci    = ~cin;
      for (int i = 0; i < NWORDS; i++) begin
         g = rnd_gap ? (($urandom_range(7) == 0) ? 1 : 0) : gap;
         for (int k = 0; k < g; k++) begin
            in_valid = 1'b0;
            start    = poke;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            if (!rnd_gap) check_val("in_ready_gap", in_ready, 1);
            @(posedge clk); #1;
         end
         start    = 1'b0;
         in_valid = 1'b1;
         a        = av[i*WIDTH +: WIDTH];
         b        = bv[i*WIDTH +: WIDTH];
         check_val("in_ready_run", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!rnd_gap) begin
         check_val("done_latency", done, 1);
         check_val("busy_done", busy, 1);
         check_val("in_ready_done", in_ready, 0);
      end
      @(posedge clk); #1;
      if (!rnd_gap) begin
         check_val("done_one_cycle", done, 0);
         check_val("busy_idle", busy, 0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TW-1:0] ra, rb;
      logic          rc;
      int            mode;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_in_ready", in_ready, 0);
      check_val("rst_z", z, 0);
      rst = 1'b0;

      // start accepted on the first cycle after reset release
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b0);
      check_val("z_after_op1", z, 1);
      do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0);
      check_val("z_carry_drop", z, 1);
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) begin
         check_val("z_hold", z, 0);
         @(posedge clk); #1;
      end
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3, 1'b0, 1'b0);
      check_val("z_gapped", z, 1);

      // abort after two transfers: no done, z cleared
      start = 1'b1; ci = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; a = 8'hFF; b = 8'h00;
         @(posedge clk); #1;
      end
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      check_val("abort_busy", busy, 0);
      check_val("abort_done", done, 0);
      check_val("abort_in_ready", in_ready, 0);
      check_val("abort_z", z, 0);
      repeat (2) @(posedge clk);
      #1;
      check_val("abort_idle", busy, 0);
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b0);
      check_val("z_after_abort", z, 1);

      // in_valid in IDLE is ignored; start during RUN is ignored
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 8'h5A; b = 8'h3C;
         @(posedge clk); #1;
         check_val("idle_busy", busy, 0);
         check_val("idle_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      do_op(32'h1234_5678, 32'hEDCB_A988, 1'b0, 2, 1'b0, 1'b1);
      do_op(32'h1234_5678, 32'hEDCB_A987, 1'b0, 2, 1'b0, 1'b1);
      check_val("z_poke_nonzero", z, 0);
      do_op(32'h1234_5678, 32'hEDCB_A987, 1'b1, 1, 1'b0, 1'b1);

      for (int n = 0; n < 10000; n++) begin
         ra   = TW'($urandom);
         rc   = 1'($urandom_range(1));
         mode = $urandom_range(3);
         if (mode == 0)      rb = -ra - {{(TW-1){1'b0}}, rc};
         else if (mode == 1) rb = (-ra - {{(TW-1){1'b0}}, rc}) ^ (TW'(1) << $urandom_range(TW-1));
         else                rb = TW'($urandom);
         do_op(ra, rb, rc, 0, 1'b1, 1'b0);
      end

      repeat (3) @(posedge clk);
      check_val("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
